conv1d_window_buffer: RTL
=========================

Name: conv1d_window_buffer

Overview:
- Upstream feeder for the conv1d stage. Accepts one D-channel activation vector per input strobe and keeps a ring of recent vectors.
- Presents four time-tapped vectors (kernel taps 0..3) on packed_a0..packed_a3 with a run-time selectable dilation.
- Asserts out_v once the window holds enough history for a full causal convolution step.

Parameters:
- W, 16, bits per element (signed, matches conv1d W).
- D, 8, channels per vector; packed port width is D*W.
- MAX_DIL, 4, largest supported dilation; ring depth DEPTH = 3*MAX_DIL+1 (13 at default).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- clear  in  1  synchronous flush of history (fill count to 0).
- dilation  in  $clog2(MAX_DIL+1)  tap spacing d; 0 treated as 1; values >MAX_DIL clamp to MAX_DIL.
- in_v  in  1  single-cycle strobe; packed_in valid.
- packed_in  in  D*W  new activation vector, element 0 in MSBs.
- packed_a0  out  D*W  tap 0 = sample t-3d (oldest).
- packed_a1  out  D*W  tap 1 = sample t-2d.
- packed_a2  out  D*W  tap 2 = sample t-d.
- packed_a3  out  D*W  tap 3 = sample t (the vector just accepted).
- out_v  out  1  one-cycle pulse: taps updated and valid.
- fill  out  $clog2(DEPTH+1)  number of valid history entries, saturating at DEPTH.

Behaviour:
- Reset: packed_a0..a3 = 0, out_v = 0, fill = 0, wr_ptr = 0, dil_q = 1. Ring contents are not reset; they are never exposed while fill is too low.
- Effective dilation d_eff = clamp(max(dilation,1), MAX_DIL). It is registered each cycle into dil_q.
- Dilation change: if d_eff != dil_q, the ring is flushed. fill <= 0, no out_v that cycle, and any coincident in_v is dropped.
- clear: has priority over in_v. fill <= 0, wr_ptr unchanged, coincident sample dropped, out_v = 0.
- Accept (in_v=1, no clear/flush) at edge n:
  - Read taps combinationally from the ring before the write: a2 = ring[wr_ptr-d], a1 = ring[wr_ptr-2d], a0 = ring[wr_ptr-3d]. All indices are mod DEPTH with wrap handled by conditional add of DEPTH; no modulo operator.
  - a3 = packed_in (bypass).
  - Write ring[wr_ptr] <= packed_in; wr_ptr <= (wr_ptr==DEPTH-1) ? 0 : wr_ptr+1; fill <= min(fill+1, DEPTH).
  - If fill (pre-increment) >= 3*d_eff: register the taps into packed_a0..a3 and set out_v=1 in the cycle after edge n (latency 1).
  - Otherwise: packed outputs unchanged, out_v = 0 (warm-up).
- out_v is high for exactly one cycle per qualifying accept. Outputs hold their last values between pulses.
- Back-to-back in_v on every cycle is supported: one out_v per cycle once warm.
- No arithmetic on data; vectors pass bit-exact. Lane order is preserved (element i at bits [(D-i)*W-1:(D-i-1)*W]).
- rst asserted mid-stream: immediate return to reset values. The first out_v after release requires 3*d_eff+1 fresh accepts.
- Downstream contract: conv1d begins its computation on out_v; the producer must not strobe in_v faster than the consumer's throughput (not checked here).

Decomposition:
- Shared package conv_pkg: W, D, K=4 (tap count) constants; typedef vec_t = logic signed [D*W-1:0]; function clamp_dil. Shared with conv1d.
- One sub-module: conv1d_ring_ram (DEPTH x D*W register array, 1 sync write port, 3 async read ports with address inputs). The top level holds the pointer, fill counter, dilation logic and output registers.

Test Plan:
- Warm-up, d=1: send vectors with all lanes = n for n=1..5 → no out_v for n=1..3. At n=4: out_v with a0..a3 lanes = 1,2,3,4. At n=5: 2,3,4,5.
- Dilation 2: dilation=2, send n=1..8 → first out_v at n=7 with taps 1,3,5,7. At n=8: taps 2,4,6,8.
- Wrap-around, d=MAX_DIL=4: stream n=1..30 continuously → out_v from n=13 onward, every cycle. At n=30: taps 18,22,26,30, checked across the pointer wrap at 13 and 26.
- Clear and dilation change: d=1, send 1..5; clear with in_v=1 carrying 6 → fill=0, no out_v, 6 dropped. Then 7..10 → out_v only at 10 with taps 7,8,9,10. Repeat, switching dilation mid-stream → same flush behaviour.
- Async reset mid-stream: assert rst between strobes while warm → out_v=0, outputs 0, fill=0 immediately. After release, 4 accepts are needed before the next out_v.
- Edge values: dilation=0 behaves as 1; dilation=7 (above MAX_DIL) behaves as 4. Lane vectors 16'h8000/16'h7FFF in distinct lanes → pass bit-exact in correct lane positions.

Source files
------------

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared conv1d constants, vector type and dilation clamp helper
package conv_pkg;

  localparam int W = 16;
  localparam int D = 8;
  localparam int K = 4;

  typedef logic signed [D*W-1:0] vec_t;

  // 0 means "no spacing requested" and behaves as 1; anything past the ring's reach saturates
  function automatic int unsigned clamp_dil(input int unsigned dil, input int unsigned max_dil);
    if (dil == 0) return 1;
    if (dil > max_dil) return max_dil;
    return dil;
  endfunction

endpackage

// File: rtl/conv1d_ring_ram.sv
// rtl/conv1d_ring_ram.sv - history ring storage, one sync write port and three async read ports
module conv1d_ring_ram #(
  parameter int DEPTH = 13,
  parameter int DW    = 128,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr0,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/conv1d_window_buffer.sv
// rtl/conv1d_window_buffer.sv - dilated four-tap activation window feeding the conv1d stage
module conv1d_window_buffer #(
  parameter int W       = conv_pkg::W,
  parameter int D       = conv_pkg::D,
  parameter int MAX_DIL = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clear,
  input  logic [$clog2(MAX_DIL+1)-1:0]        dilation,
  input  logic                                in_v,
  input  logic [D*W-1:0]                      packed_in,
  output logic [D*W-1:0]                      packed_a0,
  output logic [D*W-1:0]                      packed_a1,
  output logic [D*W-1:0]                      packed_a2,
  output logic [D*W-1:0]                      packed_a3,
  output logic                                out_v,
  output logic [$clog2((conv_pkg::K-1)*MAX_DIL+2)-1:0] fill
);
  import conv_pkg::*;

  localparam int DW     = D*W;
  localparam int DEPTH  = (K-1)*MAX_DIL+1;
  localparam int DIL_W  = $clog2(MAX_DIL+1);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = $clog2(DEPTH+1);

  logic [DIL_W-1:0]  d_eff;
  logic [DIL_W-1:0]  dil_q;
  logic [PTR_W-1:0]  wr_ptr;
  logic              flush;
  logic              accept;
  logic [PTR_W:0]    off1, off2, off3;
  logic [PTR_W-1:0]  ra0, ra1, ra2;
  logic [DW-1:0]     rd0, rd1, rd2;
  logic [FILL_W-1:0] thr;

  // Offsets never exceed DEPTH-1, so one conditional add of DEPTH undoes any borrow
  function automatic logic [PTR_W-1:0] tap_addr(input logic [PTR_W-1:0] ptr, input logic [PTR_W:0] off);
    logic [PTR_W:0] diff;
    diff = {1'b0, ptr} - off;
    if (diff[PTR_W]) diff = diff + (PTR_W+1)'(DEPTH);
    return diff[PTR_W-1:0];
  endfunction

  assign d_eff  = DIL_W'(clamp_dil(32'(dilation), MAX_DIL));
  assign flush  = (d_eff != dil_q);
  assign accept = in_v && !clear && !flush;

  assign off1 = (PTR_W+1)'(dil_q);
  assign off2 = off1 << 1;
  assign off3 = off1 + off2;
  assign thr  = FILL_W'(off3);

  assign ra2 = tap_addr(wr_ptr, off1);
  assign ra1 = tap_addr(wr_ptr, off2);
  assign ra0 = tap_addr(wr_ptr, off3);

  conv1d_ring_ram #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (PTR_W)
  ) u_ring (
    .clk    (clk),
    .we     (accept),
    .waddr  (wr_ptr),
    .wdata  (packed_in),
    .raddr0 (ra0),
    .raddr1 (ra1),
    .raddr2 (ra2),
    .rdata0 (rd0),
    .rdata1 (rd1),
    .rdata2 (rd2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      packed_a0 <= '0;
      packed_a1 <= '0;
      packed_a2 <= '0;
      packed_a3 <= '0;
      out_v     <= 1'b0;
      fill      <= '0;
      wr_ptr    <= '0;
      dil_q     <= DIL_W'(1);
    end else begin
      dil_q <= d_eff;
      out_v <= 1'b0;
      if (clear || flush) begin
        fill <= '0;
      end else if (in_v) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
        fill   <= (fill == FILL_W'(DEPTH)) ? fill : fill + 1'b1;
        // Taps are read from the ring before this edge's write lands
        if (fill >= thr) begin
          packed_a0 <= rd0;
          packed_a1 <= rd1;
          packed_a2 <= rd2;
          packed_a3 <= packed_in;
          out_v     <= 1'b1;
        end
      end
    end
  end

endmodule
